// File: rtl/link_pkg.sv
// Shared types and helpers for the round-robin link arbiter.
package link_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_REL  = 2'd3
    } link_state_e;

    localparam int LINK_DATA_W = 8;

    // Pointer width for an n-entry round-robin; never narrower than one bit.
    function automatic int link_ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/link_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module link_rr_pick
    import link_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = link_ptr_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     pick_o,
    output logic             valid_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            // ptr_i < N and k < N, so a single subtraction wraps the index.
            sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/link_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack slave among N_MASTERS masters.
// Optional S_REQ abort timer enabled by defining LINK_ARB_TIMEOUT_EN.
module link_rr_arbiter
    import link_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int DATA_W         = LINK_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*DATA_W-1:0]   m_data,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic                          s_req,
    output logic [DATA_W-1:0]             s_data,
    input  logic                          s_ack,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int PTR_W = link_ptr_w(N_MASTERS);

    link_state_e              state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [N_MASTERS-1:0]     grant_q, grant_d;
    logic [N_MASTERS-1:0]     m_ack_q, m_ack_d;
    logic                     s_req_q, s_req_d;
    logic [DATA_W-1:0]        s_data_q, s_data_d;
    logic                     done_q, done_d;

    logic [N_MASTERS-1:0]     pick;
    logic                     pick_valid;
    logic [DATA_W-1:0]        pick_data;
    logic [PTR_W-1:0]         gidx;
    logic [PTR_W-1:0]         ptr_next;
    logic                     g_req;

`ifdef LINK_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
`else
    logic                     unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    link_rr_pick #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (m_req),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick[i]) begin
                pick_data = m_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                gidx = PTR_W'(i);
            end
        end
    end

    // The served master drops to lowest priority for the next round.
    assign ptr_next = (gidx == PTR_W'(N_MASTERS - 1)) ? '0 : gidx + 1'b1;
    assign g_req    = |(m_req & grant_q);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        m_ack_d  = m_ack_q;
        s_req_d  = s_req_q;
        s_data_d = s_data_q;
        done_d   = 1'b0;
`ifdef LINK_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // The done cycle is a dead cycle: no back-to-back grant.
                if (pick_valid && !done_q) begin
                    grant_d  = pick;
                    s_data_d = pick_data;
                    s_req_d  = 1'b1;
                    state_d  = S_REQ;
`ifdef LINK_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            S_REQ: begin
                if (s_ack) begin
                    m_ack_d = grant_q;
                    state_d = S_ACK;
                end
`ifdef LINK_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    s_req_d = 1'b0;
                    grant_d = '0;
                    m_ack_d = '0;
                    err_d   = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_ACK: begin
                if (!g_req) begin
                    s_req_d = 1'b0;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!s_ack) begin
                    m_ack_d = '0;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            m_ack_q  <= '0;
            s_req_q  <= 1'b0;
            s_data_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            m_ack_q  <= m_ack_d;
            s_req_q  <= s_req_d;
            s_data_q <= s_data_d;
            done_q   <= done_d;
        end
    end

`ifdef LINK_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign m_ack  = m_ack_q;
    assign s_req  = s_req_q;
    assign s_data = s_data_q;
    assign grant  = grant_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_link_rr_arbiter.sv
// Directed self-checking bench for link_rr_arbiter (4 masters, 8-bit data).
module tb_link_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_ack;
    logic            s_req;
    logic [DW-1:0]   s_data;
    logic            s_ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            done;
    logic            err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    link_rr_arbiter #(
        .N_MASTERS      (N),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_data (m_data),
        .m_ack  (m_ack),
        .s_req  (s_req),
        .s_data (s_data),
        .s_ack  (s_ack),
        .grant  (grant),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transfer with a zero-latency slave, starting in S_IDLE with requests set.
    task automatic serve(input string tag, input logic [N-1:0] g, input logic [DW-1:0] d,
                         input bit hold, input bit corrupt);
        tick();
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_sreq_hi"}, 32'(s_req), 32'd1);
        check({tag, "_sdata_req"}, 32'(s_data), 32'(d));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_mack_lo"}, 32'(m_ack), 32'd0);
        if (corrupt) m_data = '1;
        s_ack = 1'b1;
        tick();
        check({tag, "_mack"}, 32'(m_ack), 32'(g));
        check({tag, "_sdata_ack"}, 32'(s_data), 32'(d));
        m_req = m_req & ~g;
        tick();
        check({tag, "_sreq_lo"}, 32'(s_req), 32'd0);
        check({tag, "_mack_rel"}, 32'(m_ack), 32'(g));
        check({tag, "_sdata_rel"}, 32'(s_data), 32'(d));
        s_ack = 1'b0;
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_grant_clr"}, 32'(grant), 32'd0);
        check({tag, "_mack_clr"}, 32'(m_ack), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        if (hold) m_req = m_req | g;
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_no_b2b"}, 32'(grant), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        m_req  = '0;
        m_data = 32'h0000_00A5;
        s_ack  = 1'b0;
        repeat (3) tick();
        check("rst_sreq", 32'(s_req), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_mack", 32'(m_ack), 32'd0);
        check("rst_sdata", 32'(s_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Single master, slave acks two cycles after the request rises.
        m_req = 4'b0001;
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_sreq", 32'(s_req), 32'd1);
        check("t1_sdata", 32'(s_data), 32'hA5);
        tick();
        check("t1_wait_mack", 32'(m_ack), 32'd0);
        check("t1_wait_sreq", 32'(s_req), 32'd1);
        s_ack = 1'b1;
        tick();
        check("t1_mack", 32'(m_ack), 32'h1);
        tick();
        check("t1_mack_hold", 32'(m_ack), 32'h1);
        check("t1_sreq_hold", 32'(s_req), 32'd1);
        m_req = 4'b0000;
        tick();
        check("t1_sreq_lo", 32'(s_req), 32'd0);
        check("t1_mack_rel", 32'(m_ack), 32'h1);
        s_ack = 1'b0;
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_grant_clr", 32'(grant), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);

        // Pointer now 1: master 1 beats master 0.
        m_data = 32'h0000_3CA5;
        m_req  = 4'b0011;
        serve("ptr1_m1", 4'b0010, 8'h3C, 1'b0, 1'b0);
        serve("ptr1_m0", 4'b0001, 8'hA5, 1'b0, 1'b0);

        // Async reset while in S_ACK.
        m_data = 32'h0077_3CA5;
        m_req  = 4'b0100;
        tick();
        check("rst_mid_grant", 32'(grant), 32'h4);
        s_ack = 1'b1;
        tick();
        check("rst_mid_mack", 32'(m_ack), 32'h4);
        rst = 1'b1;
        #1;
        check("rst_mid_sreq", 32'(s_req), 32'd0);
        check("rst_mid_mack0", 32'(m_ack), 32'd0);
        check("rst_mid_grant0", 32'(grant), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        s_ack = 1'b0;
        m_req = '0;
        tick();
        rst = 1'b0;
        tick();

        // All four request, held: order 0,1,2,3,0 from pointer 0.
        m_data = 32'h4433_2211;
        m_req  = 4'b1111;
        serve("all_m0", 4'b0001, 8'h11, 1'b1, 1'b0);
        serve("all_m1", 4'b0010, 8'h22, 1'b1, 1'b0);
        serve("all_m2", 4'b0100, 8'h33, 1'b1, 1'b0);
        serve("all_m3", 4'b1000, 8'h44, 1'b1, 1'b0);
        serve("all_m0b", 4'b0001, 8'h11, 1'b0, 1'b0);
        m_req = '0;

        // Move pointer to 3, then masters 3 and 0: wrap-around.
        m_req = 4'b0100;
        serve("wr_m2", 4'b0100, 8'h33, 1'b0, 1'b0);
        m_req = 4'b1001;
        serve("wr_m3", 4'b1000, 8'h44, 1'b0, 1'b0);
        serve("wr_m0", 4'b0001, 8'h11, 1'b0, 1'b0);
        m_req = 4'b0011;
        serve("wr_ptr1", 4'b0010, 8'h22, 1'b0, 1'b0);
        serve("wr_ptr1_m0", 4'b0001, 8'h11, 1'b0, 1'b0);

        // Data frozen after grant even though m_data goes to FF.
        m_data = 32'h0000_5A00;
        m_req  = 4'b0010;
        serve("frz", 4'b0010, 8'h5A, 1'b0, 1'b1);

        // Granted master drops m_req while still in S_REQ.
        m_data = 32'h0000_00C3;
        m_req  = 4'b0001;
        tick();
        check("pv_grant", 32'(grant), 32'h1);
        m_req = 4'b0000;
        tick();
        check("pv_wait", 32'(s_req), 32'd1);
        s_ack = 1'b1;
        tick();
        check("pv_mack", 32'(m_ack), 32'h1);
        tick();
        check("pv_rel_sreq", 32'(s_req), 32'd0);
        s_ack = 1'b0;
        tick();
        check("pv_done", 32'(done), 32'd1);
        tick();

        // s_ack in S_IDLE is ignored.
        s_ack = 1'b1;
        tick();
        tick();
        check("idle_ack_busy", 32'(busy), 32'd0);
        check("idle_ack_grant", 32'(grant), 32'd0);
        check("idle_ack_mack", 32'(m_ack), 32'd0);
        check("idle_ack_sreq", 32'(s_req), 32'd0);
        s_ack = 1'b0;
        tick();

        m_data = 32'h0000_BE00;
        m_req  = 4'b0110;
        tick();
        check("to_grant", 32'(grant), 32'h2);
`ifdef LINK_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_wait_err", 32'(err), 32'd0);
            check("to_wait_sreq", 32'(s_req), 32'd1);
        end
        tick();
        check("to_err", 32'(err), 32'd1);
        check("to_sreq", 32'(s_req), 32'd0);
        check("to_grant_clr", 32'(grant), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        check("to_no_done", 32'(done), 32'd0);
        tick();
        check("to_err_pulse", 32'(err), 32'd0);
        check("to_next_grant", 32'(grant), 32'h4);
        check("to_next_sdata", 32'(s_data), 32'h00);
        s_ack = 1'b1;
        tick();
        check("to_next_mack", 32'(m_ack), 32'h4);
        m_req = '0;
        tick();
        s_ack = 1'b0;
        tick();
        check("to_next_done", 32'(done), 32'd1);
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("nto_sreq", 32'(s_req), 32'd1);
            check("nto_err", 32'(err), 32'd0);
        end
        check("nto_sdata", 32'(s_data), 32'hBE);
        s_ack = 1'b1;
        tick();
        check("nto_mack", 32'(m_ack), 32'h2);
        m_req = '0;
        tick();
        s_ack = 1'b0;
        tick();
        check("nto_done", 32'(done), 32'd1);
        check("nto_err_done", 32'(err), 32'd0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
